id_ex_operand_stage: RTL and testbench

- Register file plus ID/EX pipeline register; sits directly upstream of the ALU.
- Reads two source registers and resolves forwarding from EX/MEM and writeback.
- Registers the operand pair and control so that ALUop1, ALUop2 and ALUctrl are presented to the ALU one cycle after decode.
- Handles pipeline stall and flush for the execute stage.

---
 rtl/id_ex_operand_stage.sv | 155 +++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ============================================================================
// Module      : id_ex_operand_stage
// Description : Register file with EX/MEM and writeback forwarding, followed
//               by the ID/EX pipeline register that presents ALUop1, ALUop2
//               and ALUctrl to the ALU one cycle after decode. Supports
//               stall (hold) and flush (bubble) of the execute stage.
// Options     : REGFILE_A0_EN - when defined, exposes port a0 driving the
//               raw register-file contents of x10.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_operand_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] AD1,
  input  logic [ADDR_WIDTH-1:0] AD2,
  input  logic [ADDR_WIDTH-1:0] AD3,
  input  logic                  WE3,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic [DATA_WIDTH-1:0] ImmExt,
  input  logic                  ALUSrc,
  input  logic [2:0]            ALUctrlIn,
  input  logic [ADDR_WIDTH-1:0] RdIn,
  input  logic                  RegWriteIn,
  input  logic [DATA_WIDTH-1:0] FwdData,
  input  logic [ADDR_WIDTH-1:0] FwdRd,
  input  logic                  FwdWE,
  input  logic                  Stall,
  input  logic                  Flush,
  output logic [DATA_WIDTH-1:0] ALUop1,
  output logic [DATA_WIDTH-1:0] ALUop2,
  output logic [2:0]            ALUctrl,
  output logic [ADDR_WIDTH-1:0] RdOut,
  output logic                  RegWriteOut,
  output logic                  ValidOut
`ifdef REGFILE_A0_EN
  ,
  output logic [DATA_WIDTH-1:0] a0
`endif
);

  localparam int c_NUM_REGS = 2 ** ADDR_WIDTH;

  // Architectural register file; entry 0 is never written and never read.
  logic [DATA_WIDTH-1:0] r_regs [c_NUM_REGS];

  // ID/EX pipeline register contents
  logic [DATA_WIDTH-1:0] r_alu_op1;
  logic [DATA_WIDTH-1:0] r_alu_op2;
  logic [2:0]            r_alu_ctrl;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic                  r_reg_write;
  logic                  r_valid;

  // Decode-stage combinational results
  logic                  w_wb_en;
  logic [DATA_WIDTH-1:0] w_rs1_val;
  logic [DATA_WIDTH-1:0] w_rs2_val;
  logic [DATA_WIDTH-1:0] w_op2_sel;

  // A write to x0 is dropped both in the array and in the bypass path.
  assign w_wb_en = WE3 && (AD3 != '0);

  // Source resolution: x0 is hard zero, EX/MEM beats writeback, writeback
  // beats the stored value so a same-cycle write is visible to the read.
  function automatic logic [DATA_WIDTH-1:0] f_resolve(
    input logic [ADDR_WIDTH-1:0] i_src,
    input logic [DATA_WIDTH-1:0] i_stored,
    input logic                  i_fwd_we,
    input logic [ADDR_WIDTH-1:0] i_fwd_rd,
    input logic [DATA_WIDTH-1:0] i_fwd_data,
    input logic                  i_wb_we,
    input logic [ADDR_WIDTH-1:0] i_wb_rd,
    input logic [DATA_WIDTH-1:0] i_wb_data
  );
    logic [DATA_WIDTH-1:0] v_res;
    if (i_src == '0) begin
      v_res = '0;
    end else if (i_fwd_we && (i_fwd_rd == i_src)) begin
      v_res = i_fwd_data;
    end else if (i_wb_we && (i_wb_rd == i_src)) begin
      v_res = i_wb_data;
    end else begin
      v_res = i_stored;
    end
    return v_res;
  endfunction

  // Resolve both source operands and select the immediate for operand 2.
  always_comb begin
    w_rs1_val = f_resolve(AD1, r_regs[AD1], FwdWE, FwdRd, FwdData,
                          WE3, AD3, WD3);
    w_rs2_val = f_resolve(AD2, r_regs[AD2], FwdWE, FwdRd, FwdData,
                          WE3, AD3, WD3);
    w_op2_sel = ALUSrc ? ImmExt : w_rs2_val;
  end

  // Register-file write port; writes proceed regardless of stall/flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_en) begin
      r_regs[AD3] <= WD3;
    end
  end

  // ID/EX register: flush inserts a bubble, stall holds, otherwise capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_op1   <= '0;
      r_alu_op2   <= '0;
      r_alu_ctrl  <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_valid     <= 1'b0;
    end else if (Flush) begin
      r_alu_op1   <= '0;
      r_alu_op2   <= '0;
      r_alu_ctrl  <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_valid     <= 1'b0;
    end else if (!Stall) begin
      r_alu_op1   <= w_rs1_val;
      r_alu_op2   <= w_op2_sel;
      r_alu_ctrl  <= ALUctrlIn;
      r_rd        <= RdIn;
      r_reg_write <= RegWriteIn;
      r_valid     <= 1'b1;
    end
  end

  assign ALUop1      = r_alu_op1;
  assign ALUop2      = r_alu_op2;
  assign ALUctrl     = r_alu_ctrl;
  assign RdOut       = r_rd;
  assign RegWriteOut = r_reg_write;
  assign ValidOut    = r_valid;

`ifdef REGFILE_A0_EN
  localparam logic [ADDR_WIDTH-1:0] c_A0_IDX = ADDR_WIDTH'(10);

  // Raw stored value of x10, deliberately not bypassed.
  assign a0 = r_regs[c_A0_IDX];
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
// ============================================================================
// Module      : tb_id_ex_operand_stage
// Description : Self-checking bench for id_ex_operand_stage: directed vector
//               table, hand-written reset/a0 sequences and a randomized run
//               against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_operand_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] AD1, AD2, AD3, RdIn, FwdRd;
  logic          WE3, ALUSrc, RegWriteIn, FwdWE, Stall, Flush;
  logic [DW-1:0] WD3, ImmExt, FwdData;
  logic [2:0]    ALUctrlIn;
  logic [DW-1:0] ALUop1, ALUop2;
  logic [2:0]    ALUctrl;
  logic [AW-1:0] RdOut;
  logic          RegWriteOut, ValidOut;
`ifdef REGFILE_A0_EN
  logic [DW-1:0] a0;
`endif

  id_ex_operand_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3), .WD3(WD3),
    .ImmExt(ImmExt), .ALUSrc(ALUSrc), .ALUctrlIn(ALUctrlIn),
    .RdIn(RdIn), .RegWriteIn(RegWriteIn),
    .FwdData(FwdData), .FwdRd(FwdRd), .FwdWE(FwdWE),
    .Stall(Stall), .Flush(Flush),
    .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl),
    .RdOut(RdOut), .RegWriteOut(RegWriteOut), .ValidOut(ValidOut)
`ifdef REGFILE_A0_EN
    , .a0(a0)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [AW-1:0] ad1, ad2, ad3;
    logic          we3;
    logic [DW-1:0] wd3, imm;
    logic          alusrc;
    logic [2:0]    ctrl;
    logic [AW-1:0] rd;
    logic          rw;
    logic [DW-1:0] fdata;
    logic [AW-1:0] frd;
    logic          fwe, stall, flush;
    logic [DW-1:0] e_op1, e_op2;
    logic [2:0]    e_ctrl;
    logic [AW-1:0] e_rd;
    logic          e_rw, e_valid;
  } vec_t;

  vec_t vecs [10];

  // Behavioural reference model state
  logic [DW-1:0] m_regs [32];
  logic [DW-1:0] m_op1, m_op2;
  logic [2:0]    m_ctrl;
  logic [AW-1:0] m_rd;
  logic          m_rw, m_valid;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [DW-1:0] op1, input logic [DW-1:0] op2,
                               input logic [2:0] ctrl, input logic [AW-1:0] rd,
                               input logic rw, input logic valid);
    chk({tag, ".ALUop1"}, ALUop1, op1);
    chk({tag, ".ALUop2"}, ALUop2, op2);
    chk({tag, ".ALUctrl"}, DW'(ALUctrl), DW'(ctrl));
    chk({tag, ".RdOut"}, DW'(RdOut), DW'(rd));
    chk({tag, ".RegWriteOut"}, DW'(RegWriteOut), DW'(rw));
    chk({tag, ".ValidOut"}, DW'(ValidOut), DW'(valid));
  endtask

  task automatic drive_idle();
    AD1 = '0; AD2 = '0; AD3 = '0; WE3 = 1'b0; WD3 = '0; ImmExt = '0;
    ALUSrc = 1'b0; ALUctrlIn = '0; RdIn = '0; RegWriteIn = 1'b0;
    FwdData = '0; FwdRd = '0; FwdWE = 1'b0; Stall = 1'b0; Flush = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    AD1 = v.ad1; AD2 = v.ad2; AD3 = v.ad3; WE3 = v.we3; WD3 = v.wd3;
    ImmExt = v.imm; ALUSrc = v.alusrc; ALUctrlIn = v.ctrl; RdIn = v.rd;
    RegWriteIn = v.rw; FwdData = v.fdata; FwdRd = v.frd; FwdWE = v.fwe;
    Stall = v.stall; Flush = v.flush;
  endtask

  // Spec rule for one source operand, computed from the model register array.
  function automatic logic [DW-1:0] model_src(input logic [AW-1:0] s);
    if (s == 0)                     return '0;
    if (FwdWE && FwdRd == s)        return FwdData;
    if (WE3 && AD3 == s)            return WD3;
    return m_regs[s];
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    logic [DW-1:0] n1, n2;
    n1 = model_src(AD1);
    n2 = ALUSrc ? ImmExt : model_src(AD2);
    if (Flush) begin
      m_op1 = '0; m_op2 = '0; m_ctrl = '0; m_rd = '0; m_rw = 1'b0; m_valid = 1'b0;
    end else if (!Stall) begin
      m_op1 = n1; m_op2 = n2; m_ctrl = ALUctrlIn; m_rd = RdIn; m_rw = RegWriteIn; m_valid = 1'b1;
    end
    if (WE3 && AD3 != 0) m_regs[AD3] = WD3;
  endtask

  initial begin
    // Directed vectors applied in order from the reset state.
    vecs[0] = '{5'd5, 5'd0, 5'd5, 1'b1, 32'h0000_1234, 32'h0, 1'b0, 3'd1, 5'd3, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0,
                32'h0000_1234, 32'h0, 3'd1, 5'd3, 1'b1, 1'b1};
    vecs[1] = '{5'd0, 5'd5, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, 3'd2, 5'd4, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0,
                32'h0, 32'h0000_1234, 3'd2, 5'd4, 1'b0, 1'b1};
    vecs[2] = '{5'd0, 5'd0, 5'd7, 1'b1, 32'h1, 32'h0, 1'b0, 3'd3, 5'd5, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0,
                32'h0, 32'h0, 3'd3, 5'd5, 1'b1, 1'b1};
    vecs[3] = '{5'd7, 5'd7, 5'd7, 1'b1, 32'h2, 32'h0, 1'b0, 3'd4, 5'd6, 1'b1, 32'h3, 5'd7, 1'b1, 1'b0, 1'b0,
                32'h3, 32'h3, 3'd4, 5'd6, 1'b1, 1'b1};
    vecs[4] = '{5'd7, 5'd7, 5'd0, 1'b0, 32'h0, 32'hFFFF_FFF0, 1'b1, 3'd5, 5'd7, 1'b0, 32'h3, 5'd7, 1'b1, 1'b0, 1'b0,
                32'h3, 32'hFFFF_FFF0, 3'd5, 5'd7, 1'b0, 1'b1};
    vecs[5] = '{5'd7, 5'd7, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 3'd1, 5'd8, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0,
                32'h2, 32'h2, 3'd1, 5'd8, 1'b1, 1'b1};
    vecs[6] = '{5'd5, 5'd5, 5'd9, 1'b1, 32'hAA, 32'h0, 1'b0, 3'd6, 5'd9, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0,
                32'h2, 32'h2, 3'd1, 5'd8, 1'b1, 1'b1};
    vecs[7] = '{5'd9, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 3'd7, 5'd2, 1'b1, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0,
                32'h2, 32'h2, 3'd1, 5'd8, 1'b1, 1'b1};
    vecs[8] = '{5'd9, 5'd5, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 3'd2, 5'd1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0,
                32'hAA, 32'h0000_1234, 3'd2, 5'd1, 1'b0, 1'b1};
    vecs[9] = '{5'd5, 5'd5, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 3'd3, 5'd3, 1'b1, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1,
                32'h0, 32'h0, 3'd0, 5'd0, 1'b0, 1'b0};

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", '0, '0, '0, '0, 1'b0, 1'b0);
`ifdef REGFILE_A0_EN
    chk("reset.a0", a0, '0);
`endif
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      drive_vec(vecs[i]);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].e_op1, vecs[i].e_op2, vecs[i].e_ctrl,
                    vecs[i].e_rd, vecs[i].e_rw, vecs[i].e_valid);
    end

    // Asynchronous reset mid-cycle with nonzero outputs.
    drive_idle();
    AD1 = 5'd5; ALUctrlIn = 3'd6; RdIn = 5'd11; RegWriteIn = 1'b1;
    @(posedge clk);
    #1;
    chk("prereset.ALUop1", ALUop1, 32'h0000_1234);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", '0, '0, '0, '0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    drive_idle();
    AD1 = 5'd5;
    @(posedge clk);
    #1;
    check_outputs("post_rst_read", '0, '0, '0, '0, 1'b0, 1'b1);

    // Model now mirrors the known post-reset state.
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_op1 = '0; m_op2 = '0; m_ctrl = '0; m_rd = '0; m_rw = 1'b0; m_valid = 1'b1;

`ifdef REGFILE_A0_EN
    // a0 follows x10 from the cycle after the write edge.
    drive_idle();
    AD3 = 5'd10; WE3 = 1'b1; WD3 = 32'h0000_002A;
    chk("a0.before_write", a0, '0);
    model_step();
    @(posedge clk);
    #1;
    chk("a0.after_write", a0, 32'h0000_002A);
    check_outputs("a0seq", m_op1, m_op2, m_ctrl, m_rd, m_rw, m_valid);
`endif

    // Randomized run against the reference model.
    for (int n = 0; n < 400; n++) begin
      AD1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      AD2 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      AD3 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      FwdRd = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      WE3 = 1'($urandom_range(0, 1));
      FwdWE = 1'($urandom_range(0, 1));
      WD3 = $urandom;
      FwdData = $urandom;
      ImmExt = $urandom;
      ALUSrc = ($urandom_range(0, 3) == 0);
      ALUctrlIn = 3'($urandom_range(0, 7));
      RdIn = AW'($urandom_range(0, 31));
      RegWriteIn = 1'($urandom_range(0, 1));
      Stall = ($urandom_range(0, 5) == 0);
      Flush = ($urandom_range(0, 11) == 0);
      model_step();
      @(posedge clk);
      #1;
      check_outputs($sformatf("rand%0d", n), m_op1, m_op2, m_ctrl, m_rd, m_rw, m_valid);
`ifdef REGFILE_A0_EN
      chk($sformatf("rand%0d.a0", n), a0, m_regs[10]);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
